// File: rtl/lfsr16_mon_pkg.sv
// Shared types and helpers for the 16-state LFSR monitor.
// Holds the monitor state encoding, the LFSR width, the reset value
// and the LFSR next-state function.
package lfsr16_mon_pkg;

  localparam int LFSR_W = 5;

  localparam logic [LFSR_W-1:0] RESET_VAL = 5'b10000;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  // One LFSR step: shift left, feed back taps 3 and 0, with the all-zero
  // low bits forced in so the 16-state cycle closes through RESET_VAL.
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] v);
    return {v[3:0], v[3] ^ v[0] ^ (~|v[2:0])};
  endfunction

endpackage

// File: rtl/lfsr16_mon_report.sv
// Period measurement and report stream for the LFSR monitor.
// Counts steps between RESET_VAL arrivals once armed, and presents the
// result on a valid/ready holding register with a sticky overflow flag.
module lfsr16_mon_report
  import lfsr16_mon_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          arrive,
  input  logic          clr,
  input  logic          rpt_ready,
  output logic          rpt_valid,
  output logic [PW-1:0] rpt_period,
  output logic          rpt_ovf
);

  logic [PW-1:0] cnt_p1;
  logic          armed_p1;
  logic [PW-1:0] cnt_inc;
  logic          emit;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (&v) ? v : v + PW'(1);
  endfunction

  // The arriving step itself is counted, so a healthy loop reports 16.
  assign cnt_inc = sat_inc(cnt_p1);
  assign emit    = ~clr & step & arrive & armed_p1;

  // Step counter and armed flag; a load, reset, error or IDLE cycle restarts measurement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_p1   <= '0;
      armed_p1 <= 1'b0;
    end else if (clr) begin
      cnt_p1   <= '0;
      armed_p1 <= 1'b0;
    end else if (step) begin
      if (arrive) begin
        cnt_p1   <= '0;
        armed_p1 <= 1'b1;
      end else begin
        cnt_p1   <= cnt_inc;
      end
    end
  end

  // Report holding register: a new report beats a same-cycle acceptance; a held report drops new ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_valid  <= 1'b0;
      rpt_period <= '0;
      rpt_ovf    <= 1'b0;
    end else if (emit) begin
      if (!rpt_valid || rpt_ready) begin
        rpt_valid  <= 1'b1;
        rpt_period <= cnt_inc;
      end else begin
        rpt_ovf    <= 1'b1;
      end
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr16_monitor.sv
// Checking stage for the 16-state LFSR. Mirrors the LFSR with a reference
// model, flags divergence one cycle later, resynchronises to the observed
// value and measures the sequence period through lfsr16_mon_report.
// Optional build macro: LFSR_MON_SELFSYNC_EN lets a free-running step lock
// the model from IDLE; without it only lfsr_rst or a load locks.
module lfsr16_monitor
  import lfsr16_mon_pkg::*;
#(
  parameter int PW  = 8,
  parameter int ECW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lfsr_rst,
  input  logic              lfsr_cen,
  input  logic              lfsr_wen,
  input  logic [LFSR_W-1:0] lfsr_din,
  input  logic [LFSR_W-1:0] lfsr_dout,
  output logic              locked,
  output logic              err,
  output logic [ECW-1:0]    err_count,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [PW-1:0]     rpt_period,
  output logic              rpt_ovf
);

  mon_state_e        state_p1;
  logic [LFSR_W-1:0] model_p1;
  logic              tracking;
  logic              ld;
  logic              step;
  logic              mismatch;
  logic [LFSR_W-1:0] base;
  logic [LFSR_W-1:0] model_nxt;
  logic              rep_step;
  logic              rep_arrive;
  logic              rep_clr;

  function automatic logic [ECW-1:0] sat_inc_err(input logic [ECW-1:0] v);
    return (&v) ? v : v + ECW'(1);
  endfunction

  assign tracking = (state_p1 == TRACK);
  assign locked   = tracking;
  assign ld       = lfsr_cen & lfsr_wen;
  assign step     = lfsr_cen & ~lfsr_wen & ~lfsr_rst;
  assign mismatch = tracking && (model_p1 != lfsr_dout);

  // On a mismatch the update rule runs on the observed value so the model re-aligns at once.
  assign base = mismatch ? lfsr_dout : model_p1;

  // Model next state with the LFSR's own priority: reset, load, step, hold.
  always_comb begin
    model_nxt = base;
    if (lfsr_rst) begin
      model_nxt = RESET_VAL;
    end else if (ld) begin
      model_nxt = lfsr_din;
    end else if (lfsr_cen) begin
      model_nxt = lfsr16_next(base);
    end
  end

  // Lock FSM: IDLE waits for a known LFSR value, TRACK checks every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p1 <= IDLE;
    end else if (!tracking) begin
      if (lfsr_rst || ld) begin
        state_p1 <= TRACK;
      end
`ifdef LFSR_MON_SELFSYNC_EN
      else if (lfsr_cen && !lfsr_wen) begin
        state_p1 <= TRACK;
      end
`endif
    end
  end

  // Reference model register; only meaningful while TRACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (tracking || lfsr_rst || ld) begin
        model_p1 <= model_nxt;
      end
`ifdef LFSR_MON_SELFSYNC_EN
      else if (lfsr_cen) begin
        model_p1 <= lfsr16_next(lfsr_dout);
      end
`endif
    end
  end

  // Error pulse and saturating error count, registered one cycle after the mismatch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= mismatch;
      if (mismatch) begin
        err_count <= sat_inc_err(err_count);
      end
    end
  end

  assign rep_step   = tracking & step & ~mismatch;
  assign rep_arrive = (model_nxt == RESET_VAL);
  assign rep_clr    = ~tracking | lfsr_rst | ld | mismatch;

  lfsr16_mon_report #(
    .PW(PW)
  ) u_report (
    .clk        (clk),
    .rst        (rst),
    .step       (rep_step),
    .arrive     (rep_arrive),
    .clr        (rep_clr),
    .rpt_ready  (rpt_ready),
    .rpt_valid  (rpt_valid),
    .rpt_period (rpt_period),
    .rpt_ovf    (rpt_ovf)
  );

endmodule

// File: tb/tb_lfsr16_monitor.sv
// Directed bench for lfsr16_monitor. A behavioural LFSR drives lfsr_dout;
// its output can be overridden to emulate a corrupted register.
module tb_lfsr16_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lfsr_rst = 1'b0;
  logic       lfsr_cen = 1'b0;
  logic       lfsr_wen = 1'b0;
  logic [4:0] lfsr_din = 5'b0;
  logic [4:0] lfsr_dout;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic       rpt_valid;
  logic       rpt_ready = 1'b1;
  logic [7:0] rpt_period;
  logic       rpt_ovf;

  logic [4:0] lfsr = 5'b0;
  logic       force_en = 1'b0;
  logic [4:0] force_val = 5'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign lfsr_dout = force_en ? force_val : lfsr;

  function automatic logic [4:0] tb_step(input logic [4:0] v);
    logic fb;
    fb = v[3] ^ v[0] ^ (v[2:0] == 3'b000);
    return {v[3:0], fb};
  endfunction

  // Upstream LFSR; a forced output behaves like a corrupted register.
  always @(posedge clk) begin
    if (lfsr_rst) lfsr <= 5'b10000;
    else if (lfsr_cen && lfsr_wen) lfsr <= lfsr_din;
    else if (lfsr_cen) lfsr <= tb_step(lfsr_dout);
    else lfsr <= lfsr_dout;
  end

  lfsr16_monitor #(.PW(8), .ECW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .lfsr_rst   (lfsr_rst),
    .lfsr_cen   (lfsr_cen),
    .lfsr_wen   (lfsr_wen),
    .lfsr_din   (lfsr_din),
    .lfsr_dout  (lfsr_dout),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_period (rpt_period),
    .rpt_ovf    (rpt_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_rpt_valid: got %0b want 0", rpt_valid); end
    checks++; if (rpt_period !== 8'd0) begin errors++; $display("FAIL reset_rpt_period: got %0d want 0", rpt_period); end
    checks++; if (rpt_ovf !== 1'b0) begin errors++; $display("FAIL reset_rpt_ovf: got %0b want 0", rpt_ovf); end
  endtask

  task automatic test_lock_and_period();
    logic seen_err, seen_vld;
    rst = 1'b1; lfsr_rst = 1'b1; lfsr_cen = 1'b0; rpt_ready = 1'b1;
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_lfsr_rst: got %0b want 1", locked); end
    lfsr_rst = 1'b0; lfsr_cen = 1'b1;
    seen_err = 1'b0; seen_vld = 1'b0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
      if (rpt_valid !== 1'b0) seen_vld = 1'b1;
    end
    checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL healthy_no_err: got err=1 want 0"); end
    checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL first_loop_no_report: got valid=1 want 0"); end
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL first_report: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    tick();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL report_accepted: got valid=%0b want 0", rpt_valid); end
    for (int i = 0; i < 14; i++) tick();
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL second_report: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    tick();
  endtask

  task automatic test_error_resync();
    logic seen_err, seen_vld;
    force_val = 5'b00000; force_en = 1'b1;
    tick();
    force_en = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %0b want 1", err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count_one: got %0d want 1", err_count); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_single_cycle: got %0b want 0", err); end
    seen_err = 1'b0; seen_vld = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
      if (rpt_valid !== 1'b0) seen_vld = 1'b1;
    end
    checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL resync_no_err: got err=1 want 0"); end
    checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL error_disarms: got valid=1 want 0"); end
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL report_after_rearm: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    tick();
  endtask

  task automatic test_load();
    logic seen_err, seen_vld;
    lfsr_din = 5'b00111; lfsr_wen = 1'b1; lfsr_cen = 1'b1;
    tick();
    lfsr_wen = 1'b0;
    seen_err = 1'b0; seen_vld = 1'b0;
    for (int i = 0; i < 28; i++) begin
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
      if (rpt_valid !== 1'b0) seen_vld = 1'b1;
    end
    checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL load_no_err: got err=1 want 0"); end
    checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL load_first_arrival_arms_only: got valid=1 want 0"); end
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL load_report: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    tick();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL load_report_accepted: got valid=%0b want 0", rpt_valid); end
  endtask

  task automatic test_back_to_back();
    rpt_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL b2b_first: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL b2b_held: got valid=%0b want 1", rpt_valid); end
    rpt_ready = 1'b1;
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_ovf !== 1'b0 || rpt_period !== 8'd16) begin errors++; $display("FAIL b2b_new_wins: got valid=%0b ovf=%0b period=%0d want 1/0/16", rpt_valid, rpt_ovf, rpt_period); end
    tick();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got valid=%0b want 0", rpt_valid); end
  endtask

  task automatic test_overflow();
    rpt_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first: got valid=%0b ovf=%0b want 1/0", rpt_valid, rpt_ovf); end
    for (int i = 0; i < 15; i++) tick();
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16 || rpt_ovf !== 1'b1) begin errors++; $display("FAIL ovf_dropped: got valid=%0b period=%0d ovf=%0b want 1/16/1", rpt_valid, rpt_period, rpt_ovf); end
    rpt_ready = 1'b1;
    tick();
    checks++; if (rpt_valid !== 1'b0 || rpt_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got valid=%0b ovf=%0b want 0/1", rpt_valid, rpt_ovf); end
  endtask

  task automatic test_freeze();
    logic seen_err, seen_vld;
    seen_err = 1'b0; seen_vld = 1'b0;
    for (int i = 0; i < 24; i++) begin
      lfsr_cen = (i >= 5 && i < 15) ? 1'b0 : 1'b1;
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
      if (rpt_valid !== 1'b0) seen_vld = 1'b1;
    end
    lfsr_cen = 1'b1;
    checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL freeze_no_err: got err=1 want 0"); end
    checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL freeze_no_early_report: got valid=1 want 0"); end
    tick();
    checks++; if (rpt_valid !== 1'b1 || rpt_period !== 8'd16) begin errors++; $display("FAIL freeze_report: got valid=%0b period=%0d want 1/16", rpt_valid, rpt_period); end
    tick();
  endtask

  task automatic test_rst_mid();
    logic exp_lock, seen_err, bad_lock;
`ifdef LFSR_MON_SELFSYNC_EN
    exp_lock = 1'b1;
`else
    exp_lock = 1'b0;
`endif
    rst = 1'b0;
    tick();
    checks++; if (locked !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_state: got locked=%0b err_count=%0d want 0/0", locked, err_count); end
    checks++; if (rpt_valid !== 1'b0 || rpt_ovf !== 1'b0 || rpt_period !== 8'd0) begin errors++; $display("FAIL mid_rst_report: got valid=%0b ovf=%0b period=%0d want 0/0/0", rpt_valid, rpt_ovf, rpt_period); end
    rst = 1'b1;
    tick();
    checks++; if (locked !== exp_lock) begin errors++; $display("FAIL relock_first_step: got %0b want %0b", locked, exp_lock); end
    seen_err = 1'b0; bad_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
      if (locked !== exp_lock) bad_lock = 1'b1;
    end
    checks++; if (seen_err !== 1'b0 || bad_lock !== 1'b0) begin errors++; $display("FAIL after_mid_rst: got err_seen=%0b lock_wrong=%0b want 0/0", seen_err, bad_lock); end
    lfsr_rst = 1'b1;
    tick();
    lfsr_rst = 1'b0;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_lfsr_rst: got %0b want 1", locked); end
    seen_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (err !== 1'b0) seen_err = 1'b1;
    end
    checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL relock_no_err: got err=1 want 0"); end
  endtask

  task automatic test_saturate();
    force_val = 5'b00000; force_en = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    checks++; if (err_count !== 8'd255 || err !== 1'b1) begin errors++; $display("FAIL err_count_saturate: got count=%0d err=%0b want 255/1", err_count, err); end
    force_en = 1'b0;
    tick();
    checks++; if (err !== 1'b0 || err_count !== 8'd255) begin errors++; $display("FAIL sat_recover: got err=%0b count=%0d want 0/255", err, err_count); end
  endtask

  initial begin
    test_reset();
    test_lock_and_period();
    test_error_resync();
    test_load();
    test_back_to_back();
    test_overflow();
    test_freeze();
    test_rst_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
